asyn_fifo_write_arbiter: RTL
============================

Name: asyn_fifo_write_arbiter

Overview:
- Shares the single write port of asyn_fifo between NUM_REQ independent requesters, all in the FIFO write-clock domain.
- Uses round-robin arbitration with a bounded burst lock. A grant is held for up to MAX_BURST accepted beats so that consecutive words from one source stay contiguous in the FIFO.
- Tags every write with the source ID so the read side can demultiplex.
- Sits directly between the requester logic and asyn_fifo's write-side interface signals.

Parameters:
- DATA_BITS, 11, width of one data word; must match asyn_fifo DATA_BITS.
- NUM_REQ, 4, number of requesters; legal range 2..16.
- MAX_BURST, 4, maximum beats accepted per grant; legal range 1..255.
- ID_BITS, $clog2(NUM_REQ), width of the source ID; derived, never overridden.

Ports:
- clk  input  1  write-side clock.
- reset  input  1  asynchronous, active-high reset.
- req_valid  input  NUM_REQ  per-requester valid.
- req_data  input  NUM_REQ*DATA_BITS  packed words; requester k occupies bits [k*DATA_BITS +: DATA_BITS].
- req_ready  output  NUM_REQ  per-requester ready; a beat transfers when valid & ready.
- fifo_full  input  1  FIFO full flag, write domain.
- fifo_wr_en  output  1  FIFO write strobe.
- fifo_wr_data  output  DATA_BITS  FIFO write data.
- fifo_wr_id  output  ID_BITS  source ID of the current write.
- grant_id  output  ID_BITS  currently granted requester.
- busy  output  1  high while in state BURST.
- write_count  output  16  total accepted writes; wraps modulo 2^16.

Behaviour:
- Reset (asynchronous, active-high) forces:
  - state IDLE, rr_ptr 0, grant_id 0, burst_cnt 0, write_count 0;
  - busy 0, req_ready all 0, fifo_wr_en 0, fifo_wr_data 0, fifo_wr_id 0.
- Reset asserted mid-burst aborts the burst immediately. No write occurs in any cycle while reset is high.
- State IDLE:
  - req_ready is all 0 and fifo_wr_en is 0.
  - If any req_valid is set, pick the first set bit searching upward from rr_ptr with wrap-around.
  - Register the winner into grant_id, clear burst_cnt, go to BURST.
  - Arbitration therefore costs exactly 1 cycle.
- State BURST, with g = grant_id:
  - req_ready[g] = ~fifo_full; all other ready bits are 0.
  - fifo_wr_en = req_valid[g] & ~fifo_full.
  - fifo_wr_data is slice g of req_data; fifo_wr_id = g. Both are combinational from the current grant.
  - Each transfer increments burst_cnt and write_count.
- Burst termination (next state IDLE, rr_ptr <= (g+1) mod NUM_REQ):
  - (a) a transfer occurs while burst_cnt == MAX_BURST-1;
  - (b) req_valid[g] == 0 in a BURST cycle. No transfer happens in that cycle.
- fifo_full high in BURST with req_valid[g] high:
  - stall: no transfer, no count change, grant is held;
  - no timeout and no preemption.
- Round-robin fairness: with all requesters valid continuously, grants cycle 0,1,2,...,NUM_REQ-1,0...
- Throughput:
  - worst case MAX_BURST writes per MAX_BURST+1 cycles (one IDLE arbitration cycle per burst);
  - no bubble between beats inside a burst.
- A requester that deasserts valid while not granted loses nothing; valid may be withdrawn freely.
- Requester obligations (checked by assertion in the bench): req_data[g] is held stable while req_valid[g] & ~req_ready[g].
- fifo_wr_en is never high while fifo_full is high (assertion).

Decomposition:
- Shared package asyn_fifo_arb_pkg holds:
  - typedef enum logic {ARB_IDLE, ARB_BURST} arb_state_t;
  - localparam WRITE_COUNT_BITS = 16;
  - function id_bits(n), returning $clog2(n) with a minimum of 1.
- One sub-module, rr_priority_picker:
  - combinational, parameter NUM_REQ;
  - inputs req[NUM_REQ] and ptr[ID_BITS];
  - outputs found and idx[ID_BITS].
- The top level contains the state register, burst counter, output muxing and write counter.

Test Plan:
- Single requester: req 1 valid with data 0x010..0x015 (6 words), MAX_BURST=4, FIFO never full.
  - Required: grant_id=1; 4 writes, 1 IDLE cycle, then 2 writes.
  - FIFO reads 0x010..0x015 in order, all with id 1; write_count=6.
- All 4 requesters continuously valid, each streaming data = 0x100*k + beat.
  - Required: grant order 0,1,2,3,0; exactly 4 contiguous beats per grant; 20 writes in 25 cycles.
- fifo_full forced high for 3 cycles in the middle of requester 2's burst after beat 2.
  - Required: req_ready[2]=0 and fifo_wr_en=0 for 3 cycles; grant held; beats 3-4 follow with no loss or duplication.
- Requester 3 drops valid after 2 beats while requester 0 is waiting.
  - Required: one BURST cycle without a write, then IDLE, then grant_id=0 (rr_ptr wrapped from 3 to 0).
- Reset asserted mid-burst (after 2 of 4 beats), released 3 cycles later.
  - Required: all outputs 0 immediately at reset assertion; write_count=0; first grant after release goes to the lowest valid index at or after 0.
- write_count wrap: push 65537 writes.
  - Required: write_count=1 and no stall attributable to the counter.

Source files
------------

// File: rtl/asyn_fifo_arb_pkg.sv
// Shared types and helpers for the asyn_fifo write-port arbiter.
package asyn_fifo_arb_pkg;

  typedef enum logic {ARB_IDLE, ARB_BURST} arb_state_t;

  localparam int unsigned WRITE_COUNT_BITS = 16;

  // Width of an index into n requesters, never narrower than one bit.
  function automatic int unsigned id_bits(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/asyn_fifo_write_arbiter_rr_priority_picker.sv
// Round-robin priority picker: first set request bit at or above ptr,
// wrapping to the lowest set bit when nothing at or above ptr is set.
module rr_priority_picker
  import asyn_fifo_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  localparam int unsigned ID_BITS = id_bits(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_BITS-1:0] ptr,
  output logic               found,
  output logic [ID_BITS-1:0] idx
);

  logic               found_hi;
  logic [ID_BITS-1:0] idx_hi;
  logic               found_lo;
  logic [ID_BITS-1:0] idx_lo;

  // Scan downward so the lowest qualifying index is the last one written;
  // "hi" tracks candidates at or above ptr, "lo" any candidate (wrap case).
  always_comb begin
    found_hi = 1'b0;
    idx_hi   = '0;
    found_lo = 1'b0;
    idx_lo   = '0;
    for (int unsigned i = NUM_REQ; i > 0; i--) begin
      if (req[i-1]) begin
        found_lo = 1'b1;
        idx_lo   = ID_BITS'(i - 1);
        if ((i - 1) >= 32'(ptr)) begin
          found_hi = 1'b1;
          idx_hi   = ID_BITS'(i - 1);
        end
      end
    end
  end

  // Prefer the candidate at or after ptr; otherwise wrap around.
  always_comb begin
    found = found_lo;
    idx   = found_hi ? idx_hi : idx_lo;
  end

endmodule

// File: rtl/asyn_fifo_write_arbiter.sv
// Round-robin, burst-locked arbiter sharing the asyn_fifo write port between
// NUM_REQ requesters in the write-clock domain. Each write carries its source ID.
module asyn_fifo_write_arbiter
  import asyn_fifo_arb_pkg::*;
#(
  parameter int unsigned DATA_BITS = 11,
  parameter int unsigned NUM_REQ   = 4,
  parameter int unsigned MAX_BURST = 4,
  localparam int unsigned ID_BITS  = id_bits(NUM_REQ)
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_BITS-1:0]  req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic                          fifo_full,
  output logic                          fifo_wr_en,
  output logic [DATA_BITS-1:0]          fifo_wr_data,
  output logic [ID_BITS-1:0]            fifo_wr_id,
  output logic [ID_BITS-1:0]            grant_id,
  output logic                          busy,
  output logic [WRITE_COUNT_BITS-1:0]   write_count
);

  // MAX_BURST is at most 255, so an 8-bit beat counter always suffices.
  localparam int unsigned BURST_BITS = 8;

  arb_state_t                  state_q,     state_d;
  logic [ID_BITS-1:0]          rr_ptr_q,    rr_ptr_d;
  logic [ID_BITS-1:0]          grant_q,     grant_d;
  logic [BURST_BITS-1:0]       burst_cnt_q, burst_cnt_d;
  logic [WRITE_COUNT_BITS-1:0] wcount_q,    wcount_d;

  logic               pick_found;
  logic [ID_BITS-1:0] pick_idx;
  logic               gnt_valid;
  logic [DATA_BITS-1:0] gnt_data;
  logic               last_beat;
  logic [ID_BITS-1:0] next_ptr;

  rr_priority_picker #(
    .NUM_REQ(NUM_REQ)
  ) u_picker (
    .req   (req_valid),
    .ptr   (rr_ptr_q),
    .found (pick_found),
    .idx   (pick_idx)
  );

  // Select the granted requester's valid bit and data word.
  always_comb begin
    gnt_valid = 1'b0;
    gnt_data  = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if (grant_q == ID_BITS'(k)) begin
        gnt_valid = req_valid[k];
        gnt_data  = req_data[k*DATA_BITS +: DATA_BITS];
      end
    end
  end

  // Burst-end helpers: final beat of a burst, and the requester after the grant.
  always_comb begin
    last_beat = (burst_cnt_q == BURST_BITS'(MAX_BURST - 1));
    next_ptr  = (32'(grant_q) == NUM_REQ - 1) ? '0 : grant_q + ID_BITS'(1);
  end

  // Next-state and output logic; write-side outputs are live only in BURST.
  always_comb begin
    state_d      = state_q;
    rr_ptr_d     = rr_ptr_q;
    grant_d      = grant_q;
    burst_cnt_d  = burst_cnt_q;
    wcount_d     = wcount_q;
    req_ready    = '0;
    fifo_wr_en   = 1'b0;
    fifo_wr_data = '0;
    fifo_wr_id   = '0;
    busy         = 1'b0;

    case (state_q)
      ARB_IDLE: begin
        if (pick_found) begin
          grant_d     = pick_idx;
          burst_cnt_d = '0;
          state_d     = ARB_BURST;
        end
      end

      ARB_BURST: begin
        busy = 1'b1;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
          req_ready[k] = (grant_q == ID_BITS'(k)) & ~fifo_full;
        end
        fifo_wr_en   = gnt_valid & ~fifo_full;
        fifo_wr_data = gnt_data;
        fifo_wr_id   = grant_q;

        if (fifo_wr_en) begin
          burst_cnt_d = burst_cnt_q + BURST_BITS'(1);
          wcount_d    = wcount_q + WRITE_COUNT_BITS'(1);
        end

        // A full FIFO with valid still high stalls in place with the grant held.
        if (!gnt_valid || (fifo_wr_en && last_beat)) begin
          state_d  = ARB_IDLE;
          rr_ptr_d = next_ptr;
        end
      end

      default: state_d = ARB_IDLE;
    endcase
  end

  // State, pointer, grant and counter registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ARB_IDLE;
      rr_ptr_q    <= '0;
      grant_q     <= '0;
      burst_cnt_q <= '0;
      wcount_q    <= '0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      grant_q     <= grant_d;
      burst_cnt_q <= burst_cnt_d;
      wcount_q    <= wcount_d;
    end
  end

  assign grant_id    = grant_q;
  assign write_count = wcount_q;

endmodule
